// File: rtl/lcd_pkg.sv
// Shared LCD scheduler types: FSM states, HD44780 instruction bytes, init-sequence lookup.
// Pure declarations; no latency or flow control of its own.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    CLR_WAIT,
    IDLE,
    ADDR,
    CHAR
  } state_e;

  localparam int COLS = 16;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] DDRAM_SET     = 8'h80;
  localparam logic [7:0] ROW1_OFS      = 8'h40;
  localparam logic [7:0] SPACE         = 8'h20;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET_8B2L;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_INC;
      default: return CLEAR;
    endcase
  endfunction

  function automatic logic [7:0] row_addr(input logic row);
    return DDRAM_SET | (row ? ROW1_OFS : 8'h00);
  endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// 2xCOLS character shadow buffer: one synchronous write port, one combinational read port.
// Write visible after the next edge; reset fills every cell with a space.
module lcd_char_buf
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_dat,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_dat
);

  logic [7:0] mem_q [2*COLS];
  logic [7:0] mem_d [2*COLS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2*COLS; i++) mem_q[i] <= SPACE;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/lcd_refresh_sched.sv
// HD44780 command scheduler: power-up init, then streams dirty rows as (rs,data) commands.
// Registered valid/ready output, back-to-back capable; command held stable while cmd_ready is low.
module lcd_refresh_sched
  import lcd_pkg::*;
#(
  parameter int PWR_WAIT_CYC = 750000,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       wr_row,
  input  logic [3:0] wr_col,
  input  logic [7:0] wr_char,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready,
  output logic       init_done,
  output logic       busy
);

  localparam int MAX_CYC = (PWR_WAIT_CYC > CLR_WAIT_CYC) ? PWR_WAIT_CYC : CLR_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic             row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       dirty_q, dirty_d;
  logic             init_done_q, init_done_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_rs_q, cmd_rs_d;
  logic [7:0]       cmd_data_q, cmd_data_d;

  logic       xfer;
  logic [3:0] rd_col;
  logic [7:0] rd_dat;

  assign xfer   = cmd_valid_q && cmd_ready;
  // Read ahead: the column that will be presented once the current command transfers.
  assign rd_col = (state_q == CHAR) ? col_q + 4'd1 : 4'd0;

  lcd_char_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({wr_row, wr_col}),
    .wr_dat  (wr_char),
    .rd_addr ({row_q, rd_col}),
    .rd_dat  (rd_dat)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    row_d       = row_q;
    col_d       = col_q;
    dirty_d     = dirty_q;
    init_done_d = init_done_q;
    cmd_valid_d = cmd_valid_q;
    cmd_rs_d    = cmd_rs_q;
    cmd_data_d  = cmd_data_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = INIT;
          init_idx_d  = 2'd0;
          cmd_valid_d = 1'b1;
          cmd_rs_d    = 1'b0;
          cmd_data_d  = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      INIT: begin
        if (xfer) begin
          if (init_idx_q == 2'd3) begin
            // The IDLE decision cycle is the last cycle of the clear wait.
            state_d     = CLR_WAIT;
            cnt_d       = CNT_W'(CLR_WAIT_CYC - 2);
            cmd_valid_d = 1'b0;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            cmd_data_d = init_cmd(init_idx_q + 2'd1);
          end
        end
      end
      CLR_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      IDLE: begin
        if (dirty_q != 2'b00) begin
          state_d     = ADDR;
          row_d       = !dirty_q[0];
          cmd_valid_d = 1'b1;
          cmd_rs_d    = 1'b0;
          cmd_data_d  = row_addr(!dirty_q[0]);
        end
      end
      ADDR: begin
        if (xfer) begin
          dirty_d[row_q] = 1'b0;
          col_d          = 4'd0;
          state_d        = CHAR;
          cmd_rs_d       = 1'b1;
          cmd_data_d     = rd_dat;
        end
      end
      CHAR: begin
        if (xfer) begin
          if (col_q == 4'hF) begin
            state_d     = IDLE;
            cmd_valid_d = 1'b0;
          end else begin
            col_d      = col_q + 4'd1;
            cmd_data_d = rd_dat;
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    // Host write after the ADDR clear so a same-cycle write keeps the row dirty.
    if (wr_en) dirty_d[wr_row] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= CNT_W'(PWR_WAIT_CYC - 1);
      init_idx_q  <= 2'd0;
      row_q       <= 1'b0;
      col_q       <= 4'd0;
      dirty_q     <= 2'b11;
      init_done_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_rs_q    <= 1'b0;
      cmd_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dirty_q     <= dirty_d;
      init_done_q <= init_done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_rs_q    <= cmd_rs_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_rs    = cmd_rs_q;
  assign cmd_data  = cmd_data_q;
  assign init_done = init_done_q;
  assign busy      = (dirty_q != 2'b00) || (state_q != IDLE);

endmodule

// File: tb/tb_lcd_refresh_sched.sv
// Directed + randomised-backpressure bench for lcd_refresh_sched with a command scoreboard
// and an HD44780 DDRAM model fed from every accepted command.
module tb_lcd_refresh_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       wr_row = 1'b0;
  logic [3:0] wr_col = 4'd0;
  logic [7:0] wr_char = 8'h00;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready = 1'b1;
  logic       init_done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [8:0] sb_q [$];
  bit         sb_on  = 1'b1;
  bit         rnd_rdy = 1'b0;
  logic [7:0] hbuf  [32];
  logic [7:0] ddram [128];
  logic [6:0] dd_addr = 7'd0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_cmd = 9'd0;

  lcd_refresh_sched #(.PWR_WAIT_CYC(20), .CLR_WAIT_CYC(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_char   (wr_char),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic host_wr(input logic r, input logic [3:0] c, input logic [7:0] ch);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_char = ch;
    hbuf[{r, c}] = ch;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_init();
    sb_q.push_back({1'b0, 8'h38});
    sb_q.push_back({1'b0, 8'h0C});
    sb_q.push_back({1'b0, 8'h06});
    sb_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_row(input logic r);
    sb_q.push_back({1'b0, (r ? 8'hC0 : 8'h80)});
    for (int c = 0; c < 16; c++) sb_q.push_back({1'b1, hbuf[{r, 4'(c)}]});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    chk({tag, "_busy_low"}, 32'(busy), 0);
    chk({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  task automatic wait_char(input string tag, input bit any_dat, input logic [7:0] dat);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_valid && cmd_rs && (any_dat || cmd_data == dat)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_found"}, 32'(found), 1);
  endtask

  // Transfer monitor: scoreboard pop, DDRAM model, stall stability.
  always @(negedge clk) begin
    if (!rst && prev_stall)
      chk("stall_stable", {23'd0, cmd_valid, cmd_rs, cmd_data}, {23'd0, 1'b1, prev_cmd});
    if (!rst && cmd_valid && cmd_ready) begin
      if (cmd_rs) begin
        ddram[dd_addr] = cmd_data;
        dd_addr = dd_addr + 7'd1;
      end else if (cmd_data[7]) begin
        dd_addr = cmd_data[6:0];
      end else if (cmd_data == 8'h01) begin
        for (int i = 0; i < 128; i++) ddram[i] = 8'h20;
        dd_addr = 7'd0;
      end
      if (sb_on) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) chk("xfer_cmd", {23'd0, cmd_rs, cmd_data}, {23'd0, sb_q.pop_front()});
      end
    end
    prev_stall = !rst && cmd_valid && !cmd_ready;
    prev_cmd   = {cmd_rs, cmd_data};
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s0 = "HELLO WORLD";
    string s1 = "LCD OK";
    int low;
    for (int i = 0; i < 32; i++) hbuf[i] = 8'h20;
    for (int i = 0; i < 128; i++) ddram[i] = 8'h00;

    // Reset values
    tick(); tick();
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_rs", 32'(cmd_rs), 0);
    chk("rst_data", 32'(cmd_data), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_busy", 32'(busy), 1);
    rst = 1'b0;
    push_init(); push_row(1'b0); push_row(1'b1);

    // Power-up wait: first command after 20 cycles
    repeat (19) tick();
    chk("pwr_wait_still_low", 32'(cmd_valid), 0);
    tick();
    chk("pwr_wait_first_valid", 32'(cmd_valid), 1);
    chk("init_done_during_init", 32'(init_done), 0);

    // Clear-display wait window
    repeat (4) tick();
    low = 0;
    while (!cmd_valid && low < 100) begin
      low++;
      tick();
    end
    chk("clr_wait_low_cycles", low, 10);
    chk("init_done_after_clr", 32'(init_done), 1);
    wait_idle("init_frames", 200);

    // Single write to row 1 -> only a row 1 frame
    host_wr(1'b1, 4'd5, 8'h41);
    push_row(1'b1);
    wait_idle("row1_write", 100);

    // Stall on the 0x41 byte while the host overwrites that cell
    host_wr(1'b1, 4'd3, 8'h78);
    push_row(1'b1);
    wait_char("stall_target", 1'b0, 8'h41);
    cmd_ready = 1'b0;
    tick();
    chk("stall_hold_0", 32'(cmd_data), 32'h41);
    host_wr(1'b1, 4'd5, 8'h42);
    chk("stall_hold_1", 32'(cmd_data), 32'h41);
    repeat (5) tick();
    chk("stall_hold_end_valid", 32'(cmd_valid), 1);
    chk("stall_hold_end_data", 32'(cmd_data), 32'h41);
    push_row(1'b1);
    cmd_ready = 1'b1;
    wait_idle("stall_resend", 150);

    // Both rows dirty at the same time -> row 0 first
    host_wr(1'b1, 4'd0, 8'h51);
    push_row(1'b1);
    wait_char("prio_row1_char", 1'b1, 8'h00);
    cmd_ready = 1'b0;
    host_wr(1'b1, 4'd0, 8'h53);
    host_wr(1'b0, 4'd1, 8'h50);
    push_row(1'b0);
    push_row(1'b1);
    cmd_ready = 1'b1;
    wait_idle("priority", 200);

    // Reset during a row 0 CHAR stream
    host_wr(1'b0, 4'd2, 8'h5A);
    push_row(1'b0);
    wait_char("rst_mid_char", 1'b1, 8'h00);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(cmd_valid), 0);
    chk("rst_mid_init_done", 32'(init_done), 0);
    chk("rst_mid_busy", 32'(busy), 1);
    sb_q.delete();
    for (int i = 0; i < 32; i++) hbuf[i] = 8'h20;
    rst = 1'b0;
    push_init(); push_row(1'b0); push_row(1'b1);
    wait_idle("rst_replay", 400);

    // Random backpressure with host writes mid-stream, checked against DDRAM model
    sb_on = 1'b0;
    rnd_rdy = 1'b1;
    host_wr(1'b0, 4'd0, 8'h3E);
    repeat (6) tick();
    for (int i = 0; i < s0.len(); i++) begin
      host_wr(1'b0, 4'(2 + i), s0[i]);
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int i = 0; i < s1.len(); i++) begin
      host_wr(1'b1, 4'(8 + i), s1[i]);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("random", 3000);
    rnd_rdy = 1'b0;
    cmd_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++)
        chk("ddram_model", 32'(ddram[7'(r*64 + c)]), 32'(hbuf[5'(r*16 + c)]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_sched.md
Name: lcd_refresh_sched

Overview:
- Command scheduler for the HD44780-style character LCD. It sits between the application logic and the LCD bus-timing driver, which generates E/RS/RW and per-command delays.
- Holds a 2x16 character shadow buffer and runs the power-up init sequence.
- Re-sends any row the host has modified, as a stream of (rs, data) commands over a valid/ready handshake to the driver.

Parameters:
- PWR_WAIT_CYC, 750000, cycles to wait after reset before the first command (15 ms at 50 MHz).
- CLR_WAIT_CYC, 100000, extra cycles to wait after the Clear Display command is accepted (2 ms).
- COLS, 16, characters per row; fixed, not otherwise supported.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe, one character per cycle
- wr_row  in  1  target row (0/1)
- wr_col  in  4  target column (0..15)
- wr_char  in  8  ASCII character
- cmd_valid  out  1  command available to driver
- cmd_rs  out  1  0 = instruction, 1 = data
- cmd_data  out  8  command/character byte
- cmd_ready  in  1  driver accepts command this cycle
- init_done  out  1  init sequence complete
- busy  out  1  any row dirty or a command in flight

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: cmd_valid=0, cmd_rs=0, cmd_data=0x00, init_done=0, busy=1. Buffer is all 0x20 (space), dirty=2'b11, state=PWR_WAIT, wait counter loaded with PWR_WAIT_CYC-1.
- Reset mid-operation: all of the above apply on the next edge. Any pending command is dropped and cmd_valid=0 immediately.
- Handshake:
  - A transfer occurs when cmd_valid && cmd_ready.
  - cmd_rs and cmd_data are registered and held stable while cmd_valid=1 and cmd_ready=0.
  - The next command may be presented in the cycle after a transfer (back-to-back allowed).
  - cmd_valid never drops without a transfer, except on reset.
- States:
  - PWR_WAIT: counter decrements to 0, then go to INIT.
  - INIT: issue rs=0 commands 0x38, 0x0C, 0x06, 0x01 in order. After 0x01 transfers, go to CLR_WAIT.
  - CLR_WAIT: count CLR_WAIT_CYC cycles with cmd_valid=0, then set init_done=1 and go to IDLE.
  - IDLE: if dirty[0], select row 0; else if dirty[1], select row 1; else stay. Row 0 has fixed priority.
  - ADDR: present rs=0, data = 0x80 | (row ? 0x40 : 0x00). On transfer, clear dirty[row], set col=0, go to CHAR.
  - CHAR: present rs=1, data = buf[row][col]. The byte is latched into cmd_data when presented, so host writes to that location do not disturb a held command. On transfer, col increments; after col 15 transfers, return to IDLE.
- Dirty rules:
  - wr_en sets dirty[wr_row] in every state.
  - If wr_en sets dirty on the same cycle an ADDR transfer would clear it for the same row, set wins.
  - A write to a row currently being streamed leaves that row dirty, so it is re-sent in full afterwards.
- Buffer writes are accepted in every state, including PWR_WAIT and INIT. They take effect at the next edge, and a CHAR read in the following cycle sees the new value.
- busy = (dirty != 0) || (state != IDLE).
- Address arithmetic: the buffer index is {row, col}, 5 bits. The col counter is 4 bits and wraps naturally, with end-of-row detected at col==15.

Decomposition:
- Package lcd_pkg holds:
  - state enum (PWR_WAIT, INIT, CLR_WAIT, IDLE, ADDR, CHAR);
  - LCD instruction constants: FUNC_SET_8B2L=0x38, DISP_ON=0x0C, ENTRY_INC=0x06, CLEAR=0x01, DDRAM_SET=0x80, ROW1_OFS=0x40.
  - The lcdDisplay driver is later reworked to consume the same constants.
- Sub-module lcd_char_buf: a 32x8 register file with one synchronous write port and one combinational read port. Reset fills it with 0x20.

Test Plan (PWR_WAIT_CYC=20, CLR_WAIT_CYC=10):
- Reset, cmd_ready tied 1 -> cmd_valid first high at cycle 20. Sequence is 0x38, 0x0C, 0x06, 0x01 (rs=0). cmd_valid is then low for 10 cycles, init_done=1. Then 0x80 followed by 16x 0x20 (rs=1), then 0xC0 followed by 16x 0x20. busy=0 afterwards.
- After idle: write 'A' (0x41) to row1/col5 -> exactly one frame: 0xC0, then row 1 with byte 6 = 0x41. Row 0 is not sent.
- cmd_ready held 0 for 7 cycles while data 0x41 is presented, with a host write to that same location during the stall -> cmd_data stays 0x41 until transfer. Row 1 is sent again afterwards with the new char.
- Writes to row1 and row0 in the same idle window -> row 0 frame is sent before row 1 frame.
- Assert rst during the CHAR state of a row-0 refresh -> next cycle cmd_valid=0 and init_done=0. The full init plus both rows of spaces is replayed, and the previously written chars are gone.
- Randomised cmd_ready (about 50%) with a host writing a string mid-stream -> a scoreboard of the transferred stream matches a model LCD DDRAM after busy falls. No command changes while stalled.
